adc_channel_averager: RTL and testbench



---
 rtl/adc_avg_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/adc_channel_averager.sv | 93 +++++++++
 tb/tb_adc_channel_averager.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
// Shared defaults, channel-index width helper and output entry layout
// for the ADC channel averager.
package adc_avg_pkg;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AVG_LOG2   = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width of a channel tag; a 2-channel build still needs one bit.
  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Output FIFO entry at the default sizes: {chan, data}.
  typedef struct packed {
    logic [$clog2(DEF_NUM_CH)-1:0] chan;
    logic [DEF_DATA_W-1:0]         data;
  } avg_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens on the same edge. Head data reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents behind the pointers need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clear overrides any coincident push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager: sums 2^AVG_LOG2 samples per channel, emits a
// round-half-up average tagged with its channel into an output FIFO.
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [chan_w(NUM_CH)-1:0]     in_chan,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [chan_w(NUM_CH)-1:0]     out_chan,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int CH_W  = chan_w(NUM_CH);
  localparam int ACC_W = DATA_W + AVG_LOG2 + 1;
  localparam int ENT_W = CH_W + DATA_W;
  localparam logic [AVG_LOG2-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0]    HALF    = ACC_W'(1) << (AVG_LOG2 - 1);

  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [AVG_LOG2-1:0] cnt [NUM_CH];

  logic              done, pop, full, empty;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] result;
  logic [ENT_W-1:0]  push_entry, pop_entry;

  // The sum is wide enough that the rounded average of full-scale samples
  // still fits DATA_W, so no saturation is needed.
  assign sum        = acc[in_chan] + ACC_W'(in_data) + HALF;
  assign result     = DATA_W'(sum >> AVG_LOG2);
  assign done       = in_valid && !clear && (cnt[in_chan] == CNT_MAX);
  assign push_entry = {in_chan, result};
  assign pop        = out_valid && out_ready;
  assign out_valid  = !empty;
  assign {out_chan, out_data} = pop_entry;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = in_valid && !clear && (in_chan == CH_W'(c));

    // Accumulate this channel's samples; restart after the completing one.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end else if (clear) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end else if (hit) begin
        if (cnt[c] == CNT_MAX) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end else begin
          acc[c] <= acc[c] + ACC_W'(in_data);
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (done),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Sticky drop flag: a completion found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overflow <= 1'b0;
    else if (clear)                   overflow <= 1'b0;
    else if (done && full && !pop)    overflow <= 1'b1;
  end

endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed bench for adc_channel_averager at default parameters.
module tb_adc_channel_averager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_chan = '0;
  logic [11:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_chan;
  logic [11:0] out_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  adc_channel_averager dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_data(out_data),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for exactly one edge.
  task automatic sample(input logic [1:0] ch, input logic [11:0] d);
    in_valid = 1'b1; in_chan = ch; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 12'd0)  begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    total++; if (out_chan !== 2'd0)   begin bad++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) sample(2'd0, 12'(100 + i));
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
    sample(2'd0, 12'd107);
    // sum 828, (828+4)>>3 = 104
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 12'd104) begin bad++; $display("FAIL basic_data got=%0d exp=104", out_data); end
    total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL basic_chan got=%0d exp=0", out_chan); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b exp=0", out_valid); end
  endtask

  task automatic test_interleave();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) sample(2'd1, 12'd4095);
      else            sample(2'd2, 12'd0);
    end
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL ilv_level got=%0d exp=2", fifo_level); end
    total++; if (out_chan !== 2'd1 || out_data !== 12'd4095) begin bad++; $display("FAIL ilv_first got=%0d/%0d exp=1/4095", out_chan, out_data); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 12'd0) begin bad++; $display("FAIL ilv_second got=%0b/%0d/%0d exp=1/2/0", out_valid, out_chan, out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ilv_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) sample(2'd3, 12'd10);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 12'd10) begin bad++; $display("FAIL ovf_drain%0d got=%0b/%0d/%0d exp=1/3/10", k, out_valid, out_chan, out_data); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b exp=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    out_ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) sample(2'd0, 12'd5);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fp_prefill got=%0d exp=4", fifo_level); end
    for (int i = 0; i < 7; i++) sample(2'd0, 12'd20);
    out_ready = 1'b1;
    sample(2'd0, 12'd20);
    out_ready = 1'b0;
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fp_level got=%0d exp=4", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%0b exp=0", overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1 || out_data !== ((k == 3) ? 12'd20 : 12'd5)) begin bad++; $display("FAIL fp_drain%0d got=%0b/%0d exp=1/%0d", k, out_valid, out_data, (k == 3) ? 20 : 5); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) sample(2'd0, 12'd4000);
    clear = 1'b1;
    sample(2'd0, 12'd4000);
    clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample(2'd0, 12'd10);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_early%0d got=%0b exp=0", i, out_valid); end
    end
    sample(2'd0, 12'd10);
    total++; if (out_valid !== 1'b1 || out_data !== 12'd10) begin bad++; $display("FAIL clr_result got=%0b/%0d exp=1/10", out_valid, out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_single got=%0b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sample(2'd1, 12'd9);
    for (int i = 0; i < 3; i++) sample(2'd0, 12'd7);
    total++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 12'd9) begin bad++; $display("FAIL ar_pre got=%0b/%0d/%0d exp=1/1/9", out_valid, out_chan, out_data); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 12'd0 || out_chan !== 2'd0) begin bad++; $display("FAIL ar_outputs got=%0b/%0d/%0d exp=0/0/0", out_valid, out_chan, out_data); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL ar_level got=%0d exp=0", fifo_level); end
    step();
    reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) sample(2'd0, 12'd7);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_partial_lost got=%0b exp=0", out_valid); end
    sample(2'd0, 12'd7);
    total++; if (out_valid !== 1'b1 || out_data !== 12'd7) begin bad++; $display("FAIL ar_result got=%0b/%0d exp=1/7", out_valid, out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_overflow();
    test_full_pop();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
